sd_card_dat: RTL

//  Card-side DAT[3:0] responder: the SD-card end of the host's 4-bit DAT path, used as bench model and loopback target.

---
 rtl/sd_card_dat.sv | 313 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_card_dat.sv
// sd_card_dat: card-side responder for the 4-bit SD DAT bus.
// Write blocks from the host are received and their per-line CRC16 checked.
// The CRC status token is then returned, followed by a busy hold on DAT0.
// Read blocks are sent with a start nibble, an incrementing byte pattern,
// the per-line CRC16 and an end nibble.
// All outputs are registered alongside the state, so they take their new
// value on the same edge that enters a state.
module sd_card_dat #(
  parameter int BLOCK_SZ_WIDTH  = 12,
  parameter int BLOCK_CNT_WIDTH = 16,
  parameter int BUSY_CYCLES     = 8
) (
  input  logic                       sd_clk,
  input  logic                       rst,
  input  logic [BLOCK_SZ_WIDTH-1:0]  block_sz,
  input  logic [BLOCK_CNT_WIDTH-1:0] block_cnt,
  input  logic                       wr_start,
  input  logic                       rd_start,
  input  logic [3:0]                 DAT_din,
  output logic [3:0]                 DAT_dout,
  output logic                       DAT_oe,
  output logic [7:0]                 rx_byte,
  output logic                       rx_byte_vld,
  output logic                       busy,
  output logic                       crc_err,
  output logic                       done
);

  localparam int NIB_W = BLOCK_SZ_WIDTH + 1;
  localparam int PH_W  = $clog2(BUSY_CYCLES + 16);

  localparam logic [NIB_W-1:0]           NIB_ZERO = {NIB_W{1'b0}};
  localparam logic [NIB_W-1:0]           NIB_ONE  = {{(NIB_W-1){1'b0}}, 1'b1};
  localparam logic [BLOCK_SZ_WIDTH-1:0]  SZ_ZERO  = {BLOCK_SZ_WIDTH{1'b0}};
  localparam logic [BLOCK_CNT_WIDTH-1:0] BLK_ZERO = {BLOCK_CNT_WIDTH{1'b0}};
  localparam logic [BLOCK_CNT_WIDTH-1:0] BLK_ONE  = {{(BLOCK_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PH_W-1:0]            PH_ZERO  = {PH_W{1'b0}};
  localparam logic [PH_W-1:0]            PH_ONE   = PH_W'(1);
  localparam logic [PH_W-1:0]            PH_STAT  = PH_W'(4);
  localparam logic [PH_W-1:0]            PH_CRC   = PH_W'(15);
  localparam logic [PH_W-1:0]            PH_BUSY  = PH_W'(BUSY_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, W_START, W_DATA, W_CRC, W_END, W_GAP, W_STAT, W_BUSY,
    R_START, R_DATA, R_CRC, R_END, R_GAP
  } state_t;

  // One CRC16 step (x^16+x^12+x^5+1) for a single bit of one DAT line
  function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    crc16_bit = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // DAT0 bit of the 5-cycle CRC status token, indexed from its first cycle
  function automatic logic stat_bit(input logic bad, input logic [2:0] idx);
    logic [4:0] pat;
    pat = bad ? 5'b01011 : 5'b00101;
    case (idx)
      3'd0:    stat_bit = pat[4];
      3'd1:    stat_bit = pat[3];
      3'd2:    stat_bit = pat[2];
      3'd3:    stat_bit = pat[1];
      3'd4:    stat_bit = pat[0];
      default: stat_bit = 1'b1;
    endcase
  endfunction

  state_t                     state_r;
  logic [BLOCK_SZ_WIDTH-1:0]  sz_r;
  logic [BLOCK_CNT_WIDTH-1:0] blk_r;
  logic [NIB_W-1:0]           nib_r;
  logic [PH_W-1:0]            ph_r;
  logic [7:0]                 byte_r;
  logic                       lo_r;
  logic [3:0]                 hi_r;
  logic                       blk_err_r;
  logic                       stat_bad_r;
  logic [15:0]                crc_r [4];

  logic [3:0]                 tx_nib_s;
  logic [3:0]                 crc_in_s;
  logic [15:0]                crc_upd_s [4];
  logic [15:0]                crc_shl_s [4];
  logic [3:0]                 crc_msb_s;
  logic                       crc_mis_s;
  logic                       end_bad_s;
  logic [BLOCK_CNT_WIDTH-1:0] cnt_load_s;
  logic [NIB_W-1:0]           nib_load_s;

  // CRC feed (outgoing nibble on reads, sampled lines on writes) and helper values
  always_comb begin
    tx_nib_s   = 4'b0000;
    crc_in_s   = 4'b0000;
    crc_msb_s  = 4'b0000;
    if (lo_r) begin
      tx_nib_s = byte_r[3:0];
    end else begin
      tx_nib_s = byte_r[7:4];
    end
    if ((state_r == R_START) || (state_r == R_DATA)) begin
      crc_in_s = tx_nib_s;
    end else begin
      crc_in_s = DAT_din;
    end
    for (int i = 0; i < 4; i++) begin
      crc_upd_s[i] = crc16_bit(crc_r[i], crc_in_s[i]);
      crc_shl_s[i] = {crc_r[i][14:0], 1'b0};
      crc_msb_s[i] = crc_r[i][15];
    end
    crc_mis_s  = (DAT_din != crc_msb_s);
    end_bad_s  = blk_err_r | (DAT_din != 4'b1111);
    if (block_cnt == BLK_ZERO) begin
      cnt_load_s = BLK_ONE;
    end else begin
      cnt_load_s = block_cnt;
    end
    nib_load_s = {sz_r, 1'b0} - NIB_ONE;
  end

  // Transfer FSM with all bus-facing outputs registered
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      sz_r        <= SZ_ZERO;
      blk_r       <= BLK_ZERO;
      nib_r       <= NIB_ZERO;
      ph_r        <= PH_ZERO;
      byte_r      <= 8'h00;
      lo_r        <= 1'b0;
      hi_r        <= 4'h0;
      blk_err_r   <= 1'b0;
      stat_bad_r  <= 1'b0;
      for (int i = 0; i < 4; i++) crc_r[i] <= 16'h0000;
      DAT_dout    <= 4'b1111;
      DAT_oe      <= 1'b0;
      rx_byte     <= 8'h00;
      rx_byte_vld <= 1'b0;
      busy        <= 1'b0;
      crc_err     <= 1'b0;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      rx_byte_vld <= 1'b0;
      case (state_r)
        IDLE: begin
          if (wr_start) begin
            crc_err <= 1'b0;
            if (block_sz == SZ_ZERO) begin
              done <= 1'b1;
            end else begin
              state_r <= W_START;
              busy    <= 1'b1;
              sz_r    <= block_sz;
              blk_r   <= cnt_load_s;
            end
          end else if (rd_start) begin
            crc_err <= 1'b0;
            byte_r  <= 8'h00;
            lo_r    <= 1'b0;
            if (block_sz == SZ_ZERO) begin
              done <= 1'b1;
            end else begin
              state_r  <= R_START;
              busy     <= 1'b1;
              sz_r     <= block_sz;
              blk_r    <= cnt_load_s;
              DAT_oe   <= 1'b1;
              DAT_dout <= 4'b0000;
              for (int i = 0; i < 4; i++) crc_r[i] <= 16'h0000;
            end
          end
        end
        W_START: begin
          if (DAT_din == 4'b0000) begin
            state_r   <= W_DATA;
            nib_r     <= nib_load_s;
            lo_r      <= 1'b0;
            blk_err_r <= 1'b0;
            for (int i = 0; i < 4; i++) crc_r[i] <= 16'h0000;
          end
        end
        W_DATA: begin
          crc_r <= crc_upd_s;
          lo_r  <= ~lo_r;
          if (lo_r) begin
            rx_byte     <= {hi_r, DAT_din};
            rx_byte_vld <= 1'b1;
          end else begin
            hi_r <= DAT_din;
          end
          if (nib_r != NIB_ZERO) begin
            nib_r <= nib_r - NIB_ONE;
          end else begin
            state_r <= W_CRC;
            ph_r    <= PH_CRC;
          end
        end
        W_CRC: begin
          crc_r <= crc_shl_s;
          if (crc_mis_s) blk_err_r <= 1'b1;
          if (ph_r != PH_ZERO) begin
            ph_r <= ph_r - PH_ONE;
          end else begin
            state_r <= W_END;
          end
        end
        W_END: begin
          stat_bad_r <= end_bad_s;
          if (end_bad_s) crc_err <= 1'b1;
          state_r <= W_GAP;
          ph_r    <= PH_ONE;
        end
        W_GAP: begin
          if (ph_r != PH_ZERO) begin
            ph_r <= ph_r - PH_ONE;
          end else begin
            state_r  <= W_STAT;
            ph_r     <= PH_STAT;
            DAT_oe   <= 1'b1;
            DAT_dout <= {3'b111, stat_bit(stat_bad_r, 3'd0)};
          end
        end
        W_STAT: begin
          if (ph_r != PH_ZERO) begin
            ph_r     <= ph_r - PH_ONE;
            DAT_dout <= {3'b111, stat_bit(stat_bad_r, 3'd5 - ph_r[2:0])};
          end else begin
            state_r  <= W_BUSY;
            ph_r     <= PH_BUSY;
            DAT_dout <= 4'b1110;
          end
        end
        W_BUSY: begin
          if (ph_r != PH_ZERO) begin
            ph_r <= ph_r - PH_ONE;
          end else begin
            DAT_oe   <= 1'b0;
            DAT_dout <= 4'b1111;
            if (blk_r == BLK_ONE) begin
              state_r <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r <= W_START;
              blk_r   <= blk_r - BLK_ONE;
            end
          end
        end
        R_START: begin
          state_r  <= R_DATA;
          nib_r    <= nib_load_s;
          DAT_dout <= tx_nib_s;
          crc_r    <= crc_upd_s;
          lo_r     <= ~lo_r;
          if (lo_r) byte_r <= byte_r + 8'h01;
        end
        R_DATA: begin
          if (nib_r != NIB_ZERO) begin
            nib_r    <= nib_r - NIB_ONE;
            DAT_dout <= tx_nib_s;
            crc_r    <= crc_upd_s;
            lo_r     <= ~lo_r;
            if (lo_r) byte_r <= byte_r + 8'h01;
          end else begin
            state_r  <= R_CRC;
            ph_r     <= PH_CRC;
            DAT_dout <= crc_msb_s;
            crc_r    <= crc_shl_s;
          end
        end
        R_CRC: begin
          if (ph_r != PH_ZERO) begin
            ph_r     <= ph_r - PH_ONE;
            DAT_dout <= crc_msb_s;
            crc_r    <= crc_shl_s;
          end else begin
            state_r  <= R_END;
            DAT_dout <= 4'b1111;
          end
        end
        R_END: begin
          state_r  <= R_GAP;
          ph_r     <= PH_ONE;
          DAT_oe   <= 1'b0;
          DAT_dout <= 4'b1111;
        end
        R_GAP: begin
          if (ph_r != PH_ZERO) begin
            ph_r <= ph_r - PH_ONE;
          end else if (blk_r == BLK_ONE) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_r  <= R_START;
            blk_r    <= blk_r - BLK_ONE;
            DAT_oe   <= 1'b1;
            DAT_dout <= 4'b0000;
            for (int i = 0; i < 4; i++) crc_r[i] <= 16'h0000;
          end
        end
        default: begin
          state_r  <= IDLE;
          busy     <= 1'b0;
          DAT_oe   <= 1'b0;
          DAT_dout <= 4'b1111;
        end
      endcase
    end
  end

endmodule
